// File: rtl/rr_arb16_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb16_pkg
// Shared constants, FSM state type and helpers for the 16-requester
// round-robin arbiter that steers the 16:1 select mux.
//   NREQ  : number of requesters (fixed at 16)
//   SEL_W : select index width (log2 NREQ)
//   CNT_W : grant-hold watchdog counter width
// ---------------------------------------------------------------------------
package rr_arb16_pkg;

    localparam int NREQ  = 16;
    localparam int SEL_W = 4;
    localparam int CNT_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-hot decode of a select index into a grant vector.
    function automatic logic [NREQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
        return {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_arb16_pick.sv
// ---------------------------------------------------------------------------
// rr_pick16
// Purely combinational round-robin winner search. Finds the first set bit
// of req starting at position ptr and wrapping modulo 16.
//   req [15:0] : request vector
//   ptr [3:0]  : highest-priority position this round
//   any        : at least one request is set
//   idx [3:0]  : winning requester index (meaningful only when any=1)
// ---------------------------------------------------------------------------
module rr_pick16
    import rr_arb16_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [NREQ-1:0]  rot;
    logic [SEL_W-1:0] off;

    always_comb begin
        // Rotate right by ptr so that position ptr lands on bit 0; a plain
        // lowest-set-bit search then implements the wrapped priority order.
        rot = NREQ'({req, req} >> ptr);
        off = '0;
        // Descending scan: the last hit written is the lowest set bit.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        any = |req;
        // Undo the rotation; the 4-bit add wraps modulo 16 naturally.
        idx = off + ptr;
    end

endmodule

// File: rtl/rr_arb16_sel.sv
// ---------------------------------------------------------------------------
// rr_arb16_sel
// Round-robin arbiter for 16 requesters feeding a 16:1 select mux. A grant
// is locked until the owner pulses done, or until the optional watchdog
// releases it after TIMEOUT cycles. Fairness comes from a priority pointer
// that moves to one past the most recent winner.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   req[15:0] : request vector, bit i = requester i
//   done      : one-cycle completion pulse from the granted requester
//   sel[3:0]  : registered mux select index (holds after release)
//   gnt[15:0] : registered one-hot grant, 1<<sel while gnt_valid, else 0
//   gnt_valid : a grant is active
//   timeout   : one-cycle pulse, grant released by the watchdog
// Parameters: NREQ (must be 16), SEL_W (must be 4), TIMEOUT (0 = off,
// else 1..65535 cycles of grant hold).
// ---------------------------------------------------------------------------
module rr_arb16_sel #(
    parameter int NREQ    = 16,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic [NREQ-1:0]  gnt,
    output logic             gnt_valid,
    output logic             timeout
);

    import rr_arb16_pkg::*;

    if (NREQ != 16 || SEL_W != 4) begin : g_bad_size
        $error("rr_arb16_sel supports only NREQ=16, SEL_W=4");
    end
    if (TIMEOUT < 0 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("rr_arb16_sel TIMEOUT must be 0..65535");
    end

    // Watchdog fires when the counter holds the last allowed value; the
    // counter starts at 0 on the grant cycle, so the hold lasts TIMEOUT cycles.
    localparam bit               WD_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [NREQ-1:0]  gnt_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             expire;

    rr_pick16 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign expire = WD_EN && (cnt == TO_LAST);

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        sel_nxt     = sel;
        gnt_nxt     = gnt;
        valid_nxt   = gnt_valid;
        timeout_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick_idx;
                    gnt_nxt   = onehot16(pick_idx);
                    valid_nxt = 1'b1;
                    ptr_nxt   = pick_idx + SEL_W'(1);
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                // req is deliberately ignored here: the grant is locked.
                if (done || expire) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = '0;
                    valid_nxt   = 1'b0;
                    // done wins a tie with the watchdog: normal completion.
                    timeout_nxt = !done;
                end else if (cnt != {CNT_W{1'b1}}) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            sel       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            sel       <= sel_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arb16_sel.sv
// ---------------------------------------------------------------------------
// tb_rr_arb16_sel
// Drives two arbiters in parallel (watchdog off and TIMEOUT=4) with the same
// directed stimulus. A behavioural model (owner / hold-length bookkeeping and
// a wrapped linear search) predicts both every cycle; literal expectations
// pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_rr_arb16_sel;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        done = 1'b0;
    logic [15:0] req  = 16'hFFFF;

    logic [3:0]  sel0, sel4;
    logic [15:0] gnt0, gnt4;
    logic        v0, v4, to0, to4;

    int checks = 0;
    int errors = 0;

    rr_arb16_sel #(.NREQ(16), .SEL_W(4), .TIMEOUT(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .sel(sel0), .gnt(gnt0), .gnt_valid(v0), .timeout(to0)
    );

    rr_arb16_sel #(.NREQ(16), .SEL_W(4), .TIMEOUT(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .sel(sel4), .gnt(gnt4), .gnt_valid(v4), .timeout(to4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Index 0 models the watchdog-off instance, index 1 the TIMEOUT=4 one.
    int m_lim[2]   = '{0, 4};
    int m_valid[2] = '{0, 0};
    int m_sel[2]   = '{0, 0};
    int m_ptr[2]   = '{0, 0};
    int m_held[2]  = '{0, 0};   // cycles the current grant has been visible
    int m_to[2]    = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_valid[i] = 0; m_sel[i] = 0; m_ptr[i] = 0;
                m_held[i]  = 0; m_to[i]  = 0;
            end else if (m_valid[i] == 0) begin
                int w;
                w = -1;
                m_to[i] = 0;
                for (int k = 0; k < 16; k++) begin
                    int c;
                    c = (m_ptr[i] + k) % 16;
                    if (w < 0 && req[c]) w = c;
                end
                if (w >= 0) begin
                    m_valid[i] = 1;
                    m_sel[i]   = w;
                    m_ptr[i]   = (w + 1) % 16;
                    m_held[i]  = 1;
                end
            end else begin
                if (done) begin
                    m_valid[i] = 0; m_to[i] = 0;
                end else if (m_lim[i] > 0 && m_held[i] == m_lim[i]) begin
                    m_valid[i] = 0; m_to[i] = 1;
                end else begin
                    m_to[i]   = 0;
                    m_held[i] = m_held[i] + 1;
                end
            end
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        check("dut0.sel",     32'(sel0), 32'(m_sel[0]));
        check("dut0.gnt",     32'(gnt0), m_valid[0] != 0 ? (32'd1 << m_sel[0]) : 32'd0);
        check("dut0.valid",   32'(v0),   32'(m_valid[0]));
        check("dut0.timeout", 32'(to0),  32'(m_to[0]));
        check("dut4.sel",     32'(sel4), 32'(m_sel[1]));
        check("dut4.gnt",     32'(gnt4), m_valid[1] != 0 ? (32'd1 << m_sel[1]) : 32'd0);
        check("dut4.valid",   32'(v4),   32'(m_valid[1]));
        check("dut4.timeout", 32'(to4),  32'(m_to[1]));
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_out(input int inst, input string tag, input logic [3:0] s,
                              input logic [15:0] g, input logic v, input logic t);
        if (inst == 0) begin
            check({tag, ".d0.sel"}, 32'(sel0), 32'(s));
            check({tag, ".d0.gnt"}, 32'(gnt0), 32'(g));
            check({tag, ".d0.vld"}, 32'(v0),   32'(v));
            check({tag, ".d0.to"},  32'(to0),  32'(t));
        end else begin
            check({tag, ".d4.sel"}, 32'(sel4), 32'(s));
            check({tag, ".d4.gnt"}, 32'(gnt4), 32'(g));
            check({tag, ".d4.vld"}, 32'(v4),   32'(v));
            check({tag, ".d4.to"},  32'(to4),  32'(t));
        end
    endtask

    task automatic expect_both(input string tag, input logic [3:0] s,
                               input logic [15:0] g, input logic v, input logic t);
        expect_out(0, tag, s, g, v, t);
        expect_out(1, tag, s, g, v, t);
    endtask

    initial begin
        // 1. Reset with all requests asserted.
        step(); step();
        expect_both("reset", 4'd0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        expect_both("first_grant", 4'd0, 16'h0001, 1'b1, 1'b0);

        // 2. Single requester.
        done = 1'b1; step(); done = 1'b0;
        expect_both("release0", 4'd0, 16'h0000, 1'b0, 1'b0);
        req = 16'h0001;
        step();
        expect_both("single_grant", 4'd0, 16'h0001, 1'b1, 1'b0);
        step(); step();
        done = 1'b1; step(); done = 1'b0;
        expect_both("single_done", 4'd0, 16'h0000, 1'b0, 1'b0);
        step();
        expect_both("single_regrant", 4'd0, 16'h0001, 1'b1, 1'b0);
        done = 1'b1; step(); done = 1'b0;

        // 3. Full rotation with wrap; pointer is 1 here.
        req = 16'hFFFF;
        for (int k = 0; k < 18; k++) begin
            logic [3:0] e;
            e = 4'((1 + k) % 16);
            step();
            expect_both("rotate_grant", e, 16'(1) << e, 1'b1, 1'b0);
            done = 1'b1; step(); done = 1'b0;
            expect_both("rotate_idle", e, 16'h0000, 1'b0, 1'b0);
        end

        // 4. Pointer search after a grant to 4.
        req = 16'h0010;
        step();
        expect_both("grant4", 4'd4, 16'h0010, 1'b1, 1'b0);
        done = 1'b1; step(); done = 1'b0;
        req = 16'h0009;
        step();
        expect_both("search_wrap", 4'd0, 16'h0001, 1'b1, 1'b0);
        done = 1'b1; step(); done = 1'b0;
        step();
        expect_both("search_next", 4'd3, 16'h0008, 1'b1, 1'b0);
        done = 1'b1; step(); done = 1'b0;
        req = 16'h0000;
        step();
        expect_both("search_idle", 4'd3, 16'h0000, 1'b0, 1'b0);

        // 5. Watchdog: TIMEOUT=4 instance releases after 4 cycles.
        req = 16'h0100;
        step();
        expect_both("wd_grant", 4'd8, 16'h0100, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            step();
            expect_out(1, "wd_hold", 4'd8, 16'h0100, 1'b1, 1'b0);
        end
        step();
        expect_out(1, "wd_expire", 4'd8, 16'h0000, 1'b0, 1'b1);
        expect_out(0, "no_wd", 4'd8, 16'h0100, 1'b1, 1'b0);
        step();
        expect_out(1, "wd_regrant", 4'd8, 16'h0100, 1'b1, 1'b0);
        step(); step(); step();
        done = 1'b1; step(); done = 1'b0;
        expect_both("wd_done_tie", 4'd8, 16'h0000, 1'b0, 1'b0);
        req = 16'h0000;
        step();
        expect_both("wd_idle", 4'd8, 16'h0000, 1'b0, 1'b0);

        // 6. Lock against req drop, then reset mid-grant.
        req = 16'h0040;
        step();
        expect_both("lock_grant", 4'd6, 16'h0040, 1'b1, 1'b0);
        req = 16'h0000;
        step();
        expect_both("lock_hold1", 4'd6, 16'h0040, 1'b1, 1'b0);
        step();
        expect_both("lock_hold2", 4'd6, 16'h0040, 1'b1, 1'b0);
        done = 1'b1; step(); done = 1'b0;
        expect_both("lock_done", 4'd6, 16'h0000, 1'b0, 1'b0);
        req = 16'h0040;
        step();
        expect_both("regrant6", 4'd6, 16'h0040, 1'b1, 1'b0);
        step();
        rst = 1'b1; step(); rst = 1'b0;
        expect_both("mid_reset", 4'd0, 16'h0000, 1'b0, 1'b0);
        req = 16'h8001;
        step();
        expect_both("post_reset", 4'd0, 16'h0001, 1'b1, 1'b0);

        // done while idle is ignored.
        done = 1'b1; step();
        req = 16'h0000;
        step();
        expect_both("idle_done", 4'd0, 16'h0000, 1'b0, 1'b0);
        done = 1'b0;
        req = 16'h8001;
        step();
        expect_both("after_idle_done", 4'd15, 16'h8000, 1'b1, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
